// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the registered scan multiplexer.
package mux_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Scan controller: IDLE/SCAN FSM, round-robin channel index and dwell counter.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int N_CH    = 32,
  parameter int DWELL_W = 8,
  parameter int SEL_W   = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               slot_free,
  output state_t             state,
  output logic               capture,
  output logic               capture_scan,
  output logic [SEL_W-1:0]   scan_ch
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   ch;
  logic               scan_fire;
  logic               man_fire;

  // A stop pulse in SCAN suppresses the capture of that same cycle.
  assign scan_fire    = (state == ST_SCAN) && !stop && (cnt == '0) && slot_free;
  assign man_fire     = (state == ST_IDLE) && (mode == MODE_MANUAL) && slot_free;
  assign capture      = scan_fire || man_fire;
  assign capture_scan = scan_fire;
  assign scan_ch      = ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ch    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((mode == MODE_SCAN) && start && !stop) begin
            state <= ST_SCAN;
            ch    <= '0;
            cnt   <= '0;
          end
        end
        ST_SCAN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (slot_free) begin
            ch  <= (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
            cnt <= dwell;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// N-channel registered multiplexer with manual select, auto-scan and a
// valid/ready output slot.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int N_CH    = 32,
  parameter int W       = 1,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*W-1:0]  din,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  output logic [W-1:0]       dout,
  output logic [SEL_W-1:0]   dout_ch,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               sel_err,
  output logic               busy
);

  localparam int N_PAD = 1 << SEL_W;

  state_t                     state;
  logic                       capture;
  logic                       capture_scan;
  logic [SEL_W-1:0]           scan_ch;
  logic                       slot_free;
  logic [N_PAD-1:0][W-1:0]    chan;
  logic [N_PAD-1:0]           ch_ok;
  logic [SEL_W-1:0]           cap_idx;
  logic                       cap_err;
  logic [W-1:0]               cap_data;

  // Pad the channel bank to a power of two so any select value indexes
  // safely; padded slots read as zero and flag an out-of-range select.
  for (genvar k = 0; k < N_PAD; k++) begin : g_chan
    if (k < N_CH) begin : g_live
      assign chan[k]  = din[k*W +: W];
      assign ch_ok[k] = 1'b1;
    end else begin : g_pad
      assign chan[k]  = '0;
      assign ch_ok[k] = 1'b0;
    end
  end

  // Handshake: a sample transfers on a rising edge where dout_valid and
  // dout_ready are both high; while valid is high and ready low the slot is
  // occupied and dout/dout_ch/sel_err hold. A new capture may refill the
  // slot in the same cycle the held sample is accepted.
  assign slot_free = !dout_valid || dout_ready;

  assign cap_idx  = capture_scan ? scan_ch : sel;
  assign cap_err  = !capture_scan && !ch_ok[sel];
  assign cap_data = chan[cap_idx];
  assign busy     = (state == ST_SCAN);

  mux_scan_ctrl #(
    .N_CH    (N_CH),
    .DWELL_W (DWELL_W),
    .SEL_W   (SEL_W)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .start        (start),
    .stop         (stop),
    .dwell        (dwell),
    .slot_free    (slot_free),
    .state        (state),
    .capture      (capture),
    .capture_scan (capture_scan),
    .scan_ch      (scan_ch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_ch    <= '0;
      sel_err    <= 1'b0;
      dout_valid <= 1'b0;
    end else if (capture) begin
      dout       <= cap_data;
      dout_ch    <= cap_idx;
      sel_err    <= cap_err;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: manual select on 32x1 and 24x4 instances, scan,
// backpressure, stop/start collision and async reset on an 8x4 instance.
module tb_mux_scan_seq;

  typedef struct packed {
    logic [4:0] sel;
    logic [3:0] exp_dout;
    logic [4:0] exp_ch;
    logic       exp_err;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A: 32 x 1
  logic [31:0] a_din;
  logic [4:0]  a_sel, a_ch;
  logic        a_mode, a_start, a_stop, a_dout, a_valid, a_ready, a_err, a_busy;
  logic [7:0]  a_dwell;
  // instance B: 24 x 4
  logic [95:0] b_din;
  logic [4:0]  b_sel, b_ch;
  logic [3:0]  b_dout;
  logic        b_mode, b_start, b_stop, b_valid, b_ready, b_err, b_busy;
  logic [7:0]  b_dwell;
  // instance C: 8 x 4
  logic [31:0] c_din;
  logic [2:0]  c_sel, c_ch;
  logic [3:0]  c_dout;
  logic        c_mode, c_start, c_stop, c_valid, c_ready, c_err, c_busy;
  logic [7:0]  c_dwell;

  mux_scan_seq #(.N_CH(32), .W(1), .DWELL_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .sel(a_sel), .mode(a_mode),
    .start(a_start), .stop(a_stop), .dwell(a_dwell), .dout(a_dout),
    .dout_ch(a_ch), .dout_valid(a_valid), .dout_ready(a_ready),
    .sel_err(a_err), .busy(a_busy));

  mux_scan_seq #(.N_CH(24), .W(4), .DWELL_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .sel(b_sel), .mode(b_mode),
    .start(b_start), .stop(b_stop), .dwell(b_dwell), .dout(b_dout),
    .dout_ch(b_ch), .dout_valid(b_valid), .dout_ready(b_ready),
    .sel_err(b_err), .busy(b_busy));

  mux_scan_seq #(.N_CH(8), .W(4), .DWELL_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .din(c_din), .sel(c_sel), .mode(c_mode),
    .start(c_start), .stop(c_stop), .dwell(c_dwell), .dout(c_dout),
    .dout_ch(c_ch), .dout_valid(c_valid), .dout_ready(c_ready),
    .sel_err(c_err), .busy(c_busy));

  // scoreboard
  int n_pass   = 0;
  int n_checks = 0;
  logic [6:0] a_q[$];
  logic [9:0] b_q[$];
  logic [7:0] c_q[$];
  logic [6:0] a_e;
  logic [9:0] b_e;
  logic [7:0] c_e;
  bit         c_mon_en = 1'b0;
  vec_t       a_tab[32];
  vec_t       b_tab[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic vec_t b_model(input logic [4:0] s);
    vec_t v;
    v.sel      = s;
    v.exp_ch   = s;
    v.exp_err  = (s >= 5'd24);
    v.exp_dout = v.exp_err ? 4'h0 : 4'(s + 5'd5);
    return v;
  endfunction

  function automatic logic [7:0] c_model(input int k);
    return {3'(k), 1'b0, 4'(k + 1)};
  endfunction

  // Scan-instance monitor: a transfer happens on the edge after a cycle
  // where valid and ready are both high.
  always @(negedge clk) begin
    if (c_mon_en && rst_n && c_valid && c_ready) begin
      if (c_q.size() == 0) begin
        n_checks++;
        $display("FAIL c_unexpected: got ch %0d data %0h expected no sample at %0t", c_ch, c_dout, $time);
      end else begin
        c_e = c_q.pop_front();
        check("c_sample", {c_ch, c_err, c_dout}, c_e);
      end
    end
  end

  initial begin
    a_din = 32'hCCCCCCCC; a_sel = '0; a_mode = 1'b0; a_start = 1'b0; a_stop = 1'b0;
    a_dwell = '0; a_ready = 1'b1;
    for (int k = 0; k < 24; k++) b_din[k*4 +: 4] = 4'(k + 5);
    b_sel = '0; b_mode = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_dwell = '0; b_ready = 1'b1;
    for (int k = 0; k < 8; k++) c_din[k*4 +: 4] = 4'(k + 1);
    c_sel = '0; c_mode = 1'b1; c_start = 1'b0; c_stop = 1'b0; c_dwell = 8'd2; c_ready = 1'b1;

    for (int i = 0; i < 32; i++) a_tab[i] = '{5'(i), 4'((i >> 1) & 1), 5'(i), 1'b0};
    b_tab[0] = '{5'd25, 4'h0, 5'd25, 1'b1};
    b_tab[1] = '{5'd5,  4'hA, 5'd5,  1'b0};
    b_tab[2] = b_model(5'd23);
    b_tab[3] = b_model(5'd24);
    b_tab[4] = b_model(5'd31);
    b_tab[5] = b_model(5'd0);
    for (int i = 6; i < 12; i++) b_tab[i] = b_model(5'($urandom_range(0, 31)));

    // reset state
    rst_n = 1'b0;
    #12;
    check("a_reset", {a_dout, a_ch, a_valid, a_err, a_busy}, '0);
    check("b_reset", {b_dout, b_ch, b_valid, b_err, b_busy}, '0);
    check("c_reset", {c_dout, c_ch, c_valid, c_err, c_busy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // manual, 32 x 1
    for (int i = 0; i < 32; i++) begin
      a_sel = a_tab[i].sel;
      a_q.push_back({a_tab[i].exp_ch, a_tab[i].exp_err, a_tab[i].exp_dout[0]});
      tick();
      check("a_valid", a_valid, 1'b1);
      a_e = a_q.pop_front();
      check("a_sample", {a_ch, a_err, a_dout}, a_e);
    end

    // manual, 24 x 4 with out-of-range selects
    for (int i = 0; i < 12; i++) begin
      b_sel = b_tab[i].sel;
      b_q.push_back({b_tab[i].exp_ch, b_tab[i].exp_err, b_tab[i].exp_dout});
      tick();
      check("b_valid", b_valid, 1'b1);
      b_e = b_q.pop_front();
      check("b_sample", {b_ch, b_err, b_dout}, b_e);
    end

    // manual hold under backpressure, then refill on acceptance
    b_ready = 1'b0;
    b_sel   = 5'd25;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_hold", {b_valid, b_ch, b_err, b_dout},
            {1'b1, b_tab[11].exp_ch, b_tab[11].exp_err, b_tab[11].exp_dout});
    end
    b_ready = 1'b1;
    tick();
    check("b_refill", {b_valid, b_ch, b_err, b_dout}, {1'b1, 5'd25, 1'b1, 4'h0});

    // scan, dwell=2: valid one cycle in three, channels 0..7 then 0
    c_mon_en = 1'b1;
    for (int k = 0; k < 9; k++) c_q.push_back(c_model(k % 8));
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("c_busy_scan", c_busy, 1'b1);
    for (int k = 1; k <= 27; k++) begin
      tick();
      check("c_valid_cyc", c_valid, (k % 3 == 1));
    end
    c_stop = 1'b1;
    tick();
    c_stop = 1'b0;
    check("c_busy_stop", c_busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("c_idle_quiet", c_valid, 1'b0);
    end
    check("c_q_empty_scan", c_q.size(), 0);

    // scan, dwell=0, backpressure after ch3 then stop+start collision
    c_dwell = 8'd0;
    for (int k = 0; k < 5; k++) c_q.push_back(c_model(k));
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check("c_bp_ch3", {c_valid, c_ch}, {1'b1, 3'd3});
    c_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("c_bp_hold", {c_valid, c_ch, c_dout}, {1'b1, 3'd3, 4'd4});
    end
    c_ready = 1'b1;
    tick();
    check("c_bp_noskip", {c_valid, c_ch}, {1'b1, 3'd4});
    c_ready = 1'b0;
    c_stop  = 1'b1;
    c_start = 1'b1;
    tick();
    c_stop  = 1'b0;
    c_start = 1'b0;
    check("c_collide_busy", c_busy, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("c_pending", {c_busy, c_valid, c_ch}, {1'b0, 1'b1, 3'd4});
    end
    c_ready = 1'b1;
    tick();
    check("c_pending_done", c_valid, 1'b0);
    check("c_q_empty_bp", c_q.size(), 0);

    // asynchronous reset mid-scan
    c_dwell = 8'd2;
    c_ready = 1'b0;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("c_pre_reset", {c_busy, c_valid, c_ch, c_dout}, {1'b1, 1'b1, 3'd0, 4'd1});
    #1 rst_n = 1'b0;
    #1;
    check("c_async_reset", {c_dout, c_ch, c_valid, c_err, c_busy}, '0);
    check("a_async_reset", {a_dout, a_ch, a_valid, a_err, a_busy}, '0);
    #2 rst_n = 1'b1;
    c_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("c_post_reset_idle", {c_busy, c_valid}, 2'b00);
    end
    c_q.push_back(c_model(0));
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("c_restart_busy", c_busy, 1'b1);
    tick();
    check("c_restart_valid", {c_valid, c_ch}, {1'b1, 3'd0});
    c_stop = 1'b1;
    tick();
    c_stop = 1'b0;
    tick();
    check("c_q_empty_end", c_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Parametrised N-channel, W-bit registered multiplexer with manual-select and auto-scan modes and a valid/ready output handshake. It is the sequential successor to the combinational 32:1 bit mux. It sits between a packed bank of channel inputs and a downstream consumer that samples channels either on demand (manual) or in round-robin order with a programmable dwell time (scan).

## Interface
- N_CH, 32, number of input channels (≥2, any value, not only powers of two)
- W, 1, bits per channel
- DWELL_W, 8, width of dwell counter
- SEL_W (localparam), $clog2(N_CH), select/channel-index width
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  N_CH*W  packed channels; channel k = din[k*W +: W]
- sel  input  SEL_W  manual channel select
- mode  input  1  0 = manual, 1 = scan; sampled only in IDLE
- start  input  1  single-cycle pulse, starts scan (mode=1, IDLE only)
- stop  input  1  single-cycle pulse, ends scan
- dwell  input  DWELL_W  idle cycles between scan samples; sampled on every counter reload
- dout  output  W  registered sample
- dout_ch  output  SEL_W  channel index of dout
- dout_valid  output  1  dout/dout_ch/sel_err valid
- dout_ready  input  1  consumer accepts when valid&ready
- sel_err  output  1  sample taken with sel ≥ N_CH
- busy  output  1  high in SCAN

## Operation
- Output slot free ⇔ !dout_valid || dout_ready. A capture loads dout, dout_ch and sel_err and sets dout_valid. No capture while the slot is occupied. Held data is never overwritten.
- FSM states are IDLE and SCAN.
- IDLE, mode=0: capture din[sel] on every cycle the slot is free. If sel ≥ N_CH: dout=0, dout_ch=sel, sel_err=1.
- IDLE, mode=1: no captures. start → SCAN, ch=0, cnt=0.
- SCAN: when cnt==0 and the slot is free, capture channel ch, set sel_err=0, ch ← (ch==N_CH-1) ? 0 : ch+1, cnt ← dwell. Otherwise, if cnt≠0, cnt decrements.
- SCAN stall: cnt holds at 0 while the slot is occupied. No channel is skipped.
- stop in SCAN → IDLE next cycle. No further captures. A pending dout_valid stays high until accepted.
- stop and start in the same cycle: stop wins.
- start while in SCAN is ignored. mode changes while in SCAN are ignored.
- busy = (state==SCAN).
- Reset, asynchronous: state=IDLE; ch, cnt, dout, dout_ch, dout_valid, sel_err, busy all 0.

## Timing
- Manual latency: sel/din at cycle t → dout at t+1 (one register). With ready=1, one sample per cycle.
- Scan: start at t → SCAN at t+1 → first capture at the end of t+1 → dout_valid at t+2.
- Scan sample period with ready=1 is dwell+1 cycles. dwell=0 gives one sample per cycle.
- Handshake: dout, dout_ch and sel_err stay stable while dout_valid=1 and dout_ready=0. dout_valid drops the cycle after acceptance unless a new capture occurs in the same cycle.
- Channel wrap: after N_CH-1 comes 0. For non-power-of-two N_CH, the index never reaches ≥ N_CH in scan.
- Reset deasserted mid-scan: the block resumes in IDLE. Scan needs a new start.

## Structure
- Shared package mux_scan_pkg holds:
  - state enum: ST_IDLE, ST_SCAN
  - mode constants: MODE_MANUAL=0, MODE_SCAN=1
- One sub-module, mux_scan_ctrl, holds the FSM, ch and cnt. It outputs a capture strobe and the scan index.
- The top holds the indexed part-select mux, the output register and the handshake.

## Test plan
- Manual, N_CH=32, W=1, din=32'hCCCCCCCC, ready=1, sel stepped 0..31 → dout follows one cycle later: 0,0,1,1,0,0,1,1,… with dout_ch=sel and sel_err=0.
- Manual, N_CH=24, W=4, sel=25 → dout=4'h0, dout_ch=25, sel_err=1, dout_valid=1. sel=5 with din channel 5=4'hA → dout=4'hA, sel_err=0.
- Scan, N_CH=8, dwell=2, ready=1, start at t → dout_valid pulses at t+2, t+5, t+8, … with dout_ch 0,1,…,7,0 (wrap checked).
- Backpressure in scan, dwell=0: ready low for 5 cycles after ch3 is captured → dout_ch holds 3 and dout_valid stays 1. After ready rises, the next sample is ch4 (no skip).
- stop and start pulsed in the same cycle during SCAN → IDLE next cycle, busy=0, no new captures. The pending sample is still delivered.
- rst_n low mid-scan, asynchronous (between clock edges) → all outputs 0 immediately. After release the block stays in IDLE until start.
